// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read controllers.
// Latency: none (constants and combinational functions only).
// Backpressure: not applicable.
package fifo_ptr_pkg;

  // Widest pointer the helpers handle. Narrower pointers are zero-extended
  // in and truncated out. Leading zeros leave both conversions unchanged.
  localparam int MAXW = 32;

  // FIFO depth for a given RAM address width.
  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Pointer width: address bits plus the lap bit.
  function automatic int ptr_w_of(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b = '0;
    for (int i = 0; i < MAXW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_ptr.sv
// Gray-to-binary converter for a synchronised FIFO pointer.
// Latency: combinational.
// Backpressure: none.
module gray2bin_ptr
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down.
  always_comb begin
    bin = WIDTH'(gray2bin(MAXW'(gray)));
  end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer, full/almost-full/overflow flags and fill level.
// Latency: a write is accepted and stored at the same edge; all status registered after it.
// Backpressure: wfull blocks wen; a write attempted while full is dropped and sets wovf.
module wptr_full_lvl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic [ADDR_SIZE:0]   afull_thresh,
  input  logic                 ovf_clr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf
);

  localparam int PW = ptr_w_of(ADDR_SIZE);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wlevel_next;
  logic [PW-1:0] full_gray;
  logic          wfull_val;
  logic          walmost_full_val;
  logic          wovf_next;

  gray2bin_ptr #(.WIDTH(PW)) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_SIZE-1:0];

  // Gray full pattern: read pointer with its top two bits inverted.
  assign full_gray = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};

  // Next-state pointer, level and flag values.
  always_comb begin
    wbin_next        = wbin + PW'(wen);
    wgray_next       = PW'(bin2gray(MAXW'(wbin_next)));
    wlevel_next      = wbin_next - rbin_s;
    wfull_val        = (wgray_next == full_gray);
    walmost_full_val = (wlevel_next >= afull_thresh);
    // A dropped write sets the flag and takes priority over a clear.
    wovf_next        = (winc & wfull) | (wovf & ~ovf_clr);
  end

  // All write-domain state, cleared asynchronously.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wlevel       <= wlevel_next;
      wfull        <= wfull_val;
      walmost_full <= walmost_full_val;
      wovf         <= wovf_next;
    end
  end

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl at ADDR_SIZE=3: directed scenarios plus random traffic
// against a write/read word-count model of the FIFO.
// Read pointer is driven directly as Gray.
module tb_wptr_full_lvl;

  localparam int AS    = 3;
  localparam int DEPTH = 8;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic [AS:0]   wq2_rptr = '0;
  logic [AS:0]   afull_thresh = '0;
  logic          ovf_clr = 1'b0;
  logic          wen;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wlevel;
  logic          wovf;

  wptr_full_lvl #(.ADDR_SIZE(AS)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int failures = 0;

  // Model: total words accepted and total words read, as plain counts.
  int m_w, m_r, m_level;
  bit m_full, m_afull, m_ovf;

  function automatic logic [3:0] gray_of(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  // {wptr, wfull, walmost_full, wlevel, wovf, waddr}
  function automatic logic [13:0] obs();
    return {wptr, wfull, walmost_full, wlevel, wovf, waddr};
  endfunction

  function automatic logic [13:0] expv();
    return {gray_of(m_w % 16), m_full, m_afull, 4'(m_level), m_ovf, 3'(m_w % 8)};
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  // Apply one cycle's inputs; a read advance bumps the Gray read pointer.
  task automatic drive(input bit w, input bit rd, input bit clr);
    winc    = w;
    ovf_clr = clr;
    if (rd) m_r++;
    wq2_rptr = gray_of(m_r % 16);
  endtask

  // Clock edge, then update the model and settle just past the edge.
  task automatic tick();
    bit acc;
    @(posedge wclk);
    acc     = winc && !m_full;
    m_ovf   = (winc && m_full) || (m_ovf && !ovf_clr);
    if (acc) m_w++;
    m_level = m_w - m_r;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= int'(afull_thresh));
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; ovf_clr = 1'b0; afull_thresh = 4'd6;
    model_reset();
    #12;
    checks++;
    if (obs() !== 14'd0 || wen !== 1'b0) begin
      failures++;
      $display("FAIL reset outs=%h wen=%b required outs=0 wen=0", obs(), wen);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
  endtask

  task automatic test_fill();
    afull_thresh = 4'd6;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0);
      #1;
      checks++;
      if (waddr !== 3'(i - 1) || wen !== 1'b1) begin
        failures++;
        $display("FAIL fill_waddr%0d waddr=%0d wen=%b required %0d 1", i, waddr, wen, i - 1);
      end
      tick();
      checks++;
      if (obs() !== expv() || walmost_full !== (i >= 6) || wfull !== (i == 8)) begin
        failures++;
        $display("FAIL fill%0d got=%h required=%h", i, obs(), expv());
      end
    end
    checks++;
    if (wlevel !== 4'd8) begin
      failures++;
      $display("FAIL fill_level got=%0d required=8", wlevel);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      #1;
      checks++;
      if (wen !== 1'b0) begin
        failures++;
        $display("FAIL ovf_wen got=%b required=0", wen);
      end
      tick();
      checks++;
      if (wptr !== 4'b1100 || wovf !== 1'b1 || obs() !== expv()) begin
        failures++;
        $display("FAIL ovf_hold%0d wptr=%b wovf=%b required 1100 1", i, wptr, wovf);
      end
    end
    drive(0, 0, 1); tick();
    checks++;
    if (wovf !== 1'b0 || obs() !== expv()) begin
      failures++;
      $display("FAIL ovf_clear wovf=%b required=0", wovf);
    end
    drive(1, 0, 1); tick();
    checks++;
    if (wovf !== 1'b1 || obs() !== expv()) begin
      failures++;
      $display("FAIL ovf_set_wins wovf=%b required=1", wovf);
    end
    drive(0, 0, 1); tick();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL ovf_clear2 got=%h required=%h", obs(), expv());
    end
  endtask

  task automatic test_drain_wrap();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0); tick();
      checks++;
      if (obs() !== expv() || wlevel !== 4'(8 - i) || wfull !== 1'b0) begin
        failures++;
        $display("FAIL drain%0d got=%h level=%0d required=%h level=%0d", i, obs(), wlevel, expv(), 8 - i);
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, (m_r < m_w), 0); tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL wrap%0d got=%h required=%h", i, obs(), expv());
      end
    end
    checks++;
    if (m_w != 20 || wptr !== gray_of(20)) begin
      failures++;
      $display("FAIL wrap_ptr wptr=%b required=%b", wptr, gray_of(20));
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16 && m_level != 7; i++) begin
      drive(m_level < 7, m_level > 7, 0); tick();
    end
    drive(1, 1, 0); tick();
    checks++;
    if (wlevel !== 4'd7 || wfull !== 1'b0 || obs() !== expv()) begin
      failures++;
      $display("FAIL simultaneous level=%0d full=%b required 7 0", wlevel, wfull);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit w, rd, clr;
      if ($urandom_range(0, 15) == 0) afull_thresh = 4'($urandom_range(0, 9));
      w   = ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 45) && (m_r < m_w);
      clr = ($urandom_range(0, 7) == 0);
      drive(w, rd, clr);
      #1;
      checks++;
      if (wen !== (w && !m_full)) begin
        failures++;
        $display("FAIL rand_wen%0d got=%b required=%b", i, wen, (w && !m_full));
      end
      tick();
      checks++;
      if (obs() !== expv() || wfull !== (wlevel == 4'd8)) begin
        failures++;
        $display("FAIL rand%0d got=%h required=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_thresh_bounds();
    afull_thresh = 4'd0;
    drive(0, 0, 0); tick();
    checks++;
    if (walmost_full !== 1'b1) begin
      failures++;
      $display("FAIL thresh0 afull=%b required=1", walmost_full);
    end
    afull_thresh = 4'd9;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0); tick();
      checks++;
      if (walmost_full !== 1'b0 || obs() !== expv()) begin
        failures++;
        $display("FAIL thresh9_%0d afull=%b got=%h required=%h", i, walmost_full, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    afull_thresh = 4'd6;
    for (int i = 0; i < 20 && m_level != 5; i++) begin
      drive(m_level < 5, m_level > 5, 1); tick();
    end
    checks++;
    if (wlevel !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset_level got=%0d required=5", wlevel);
    end
    winc = 1'b1;
    wrst_n = 1'b0;
    model_reset();
    wq2_rptr = '0;
    #1;
    checks++;
    if (obs() !== 14'd0 || wen !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid outs=%h wen=%b required outs=0 wen=1", obs(), wen);
    end
    #2;
    wrst_n = 1'b1;
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (waddr !== 3'd2 || wlevel !== 4'd2 || obs() !== expv()) begin
      failures++;
      $display("FAIL reset_restart got=%h required=%h", obs(), expv());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_simultaneous();
    test_thresh_bounds();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
